// File: rtl/stack_pointer_unit.sv
// Main-stack and return-stack pointer registers for the JALA multicycle datapath.
// Each stack tracks depth and raises sticky overflow/underflow faults at its guards.

module stack_pointer_ctrl #(
  parameter int unsigned          ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]    BASE       = 16'h0800,
  parameter int unsigned          WORD_BYTES = 2,
  parameter int unsigned          MAX_DEPTH  = 64,
  parameter int unsigned          DEPTH_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_reset,
  input  logic               write,
  input  logic               pop,
  output logic [ADDR_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [ADDR_W-1:0]  STEP      = ADDR_W'(WORD_BYTES);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               is_empty, is_full;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_MAX);

  // Guarded pushes/pops leave pointer and depth untouched; only the flag moves.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (reg_reset) begin
      ptr_d   = BASE;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (write) begin
      if (pop) begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          ptr_d   = ptr_q + STEP;
          depth_d = depth_q - DEPTH_ONE;
        end
      end else begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          ptr_d   = ptr_q - STEP;
          depth_d = depth_q + DEPTH_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= BASE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top       = ptr_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

module stack_pointer_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] MS_BASE    = 16'h0800,
  parameter logic [ADDR_W-1:0] RS_BASE    = 16'h0400,
  parameter int unsigned       WORD_BYTES = 2,
  parameter int unsigned       MAX_DEPTH  = 64,
  parameter int unsigned       DEPTH_W    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ms_reg_reset,
  input  logic               ms_write,
  input  logic               ms_pop,
  input  logic               rs_reg_reset,
  input  logic               rs_write,
  input  logic               rs_pop,
  output logic [ADDR_W-1:0]  ms_top,
  output logic [ADDR_W-1:0]  ms_second,
  output logic [ADDR_W-1:0]  rs_top,
  output logic [DEPTH_W-1:0] ms_depth,
  output logic [DEPTH_W-1:0] rs_depth,
  output logic               ms_empty,
  output logic               rs_empty,
  output logic               ms_full,
  output logic               rs_full,
  output logic               ms_overflow,
  output logic               ms_underflow,
  output logic               rs_overflow,
  output logic               rs_underflow,
  output logic               fault
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  // A base below the full-stack footprint would let the pointer wrap through zero.
  if (64'(MS_BASE) < 64'(MAX_DEPTH) * 64'(WORD_BYTES)) begin : g_ms_base_chk
    $error("stack_pointer_unit: MS_BASE too small for MAX_DEPTH*WORD_BYTES");
  end
  if (64'(RS_BASE) < 64'(MAX_DEPTH) * 64'(WORD_BYTES)) begin : g_rs_base_chk
    $error("stack_pointer_unit: RS_BASE too small for MAX_DEPTH*WORD_BYTES");
  end
  if (64'(MAX_DEPTH) >= (64'd1 << DEPTH_W)) begin : g_depth_w_chk
    $error("stack_pointer_unit: DEPTH_W cannot hold MAX_DEPTH");
  end

  stack_pointer_ctrl #(
    .ADDR_W    (ADDR_W),
    .BASE      (MS_BASE),
    .WORD_BYTES(WORD_BYTES),
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) u_ms (
    .clk      (clk),
    .rst      (rst),
    .reg_reset(ms_reg_reset),
    .write    (ms_write),
    .pop      (ms_pop),
    .top      (ms_top),
    .depth    (ms_depth),
    .overflow (ms_overflow),
    .underflow(ms_underflow)
  );

  stack_pointer_ctrl #(
    .ADDR_W    (ADDR_W),
    .BASE      (RS_BASE),
    .WORD_BYTES(WORD_BYTES),
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) u_rs (
    .clk      (clk),
    .rst      (rst),
    .reg_reset(rs_reg_reset),
    .write    (rs_write),
    .pop      (rs_pop),
    .top      (rs_top),
    .depth    (rs_depth),
    .overflow (rs_overflow),
    .underflow(rs_underflow)
  );

  assign ms_second = ms_top + ADDR_W'(WORD_BYTES);
  assign ms_empty  = (ms_depth == '0);
  assign rs_empty  = (rs_depth == '0);
  assign ms_full   = (ms_depth == DEPTH_MAX);
  assign rs_full   = (rs_depth == DEPTH_MAX);
  assign fault     = ms_overflow | ms_underflow | rs_overflow | rs_underflow;

endmodule
